// File: rtl/send_word_as_ascii_if.sv
// Bundle between the word sender and its environment: the request side
// (send, hex_mode, binary_in, busy, done) and the uart_tx6 side
// (en_16_x_baud, buffer_full, ascii_out, data_present).
//   master : environment view (drives requests and UART status)
//   slave  : sender view (drives characters, strobes and status)
interface send_word_as_ascii_if #(
    parameter int unsigned W = 8
) ();
    logic          en_16_x_baud;
    logic          send;
    logic          hex_mode;
    logic [W-1:0]  binary_in;
    logic          buffer_full;
    logic [7:0]    ascii_out;
    logic          data_present;
    logic          busy;
    logic          done;

    modport master (
        output en_16_x_baud, send, hex_mode, binary_in, buffer_full,
        input  ascii_out, data_present, busy, done
    );

    modport slave (
        input  en_16_x_baud, send, hex_mode, binary_in, buffer_full,
        output ascii_out, data_present, busy, done
    );
endinterface

// File: rtl/send_word_as_ascii.sv
// Captures a W-bit word on send and writes it MSB-first as ASCII binary or
// uppercase hex digits into a uart_tx6 buffer, optionally followed by CR/LF.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus.slave  : en_16_x_baud, send, hex_mode, binary_in, buffer_full in;
//                ascii_out, data_present, busy, done out (all registered)
// TERM: 0 = no terminator, 1 = LF, 2 = CR then LF.
module send_word_as_ascii #(
    parameter int unsigned W    = 8,
    parameter int unsigned TERM = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    send_word_as_ascii_if.slave    bus
);

    localparam int unsigned D_HEX = (W + 3) / 4;
    // 4*ceil(W/4) is never smaller than W, so it covers both radices.
    localparam int unsigned SR_W  = 4 * D_HEX;
    localparam int unsigned CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        DIGITS,
        CR,
        LF
    } state_t;

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hex_q, hex_d;
    logic [7:0]        ascii_q, ascii_d;
    logic              dp_q, dp_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              write_c;
    logic [3:0]        nib_c;
    logic [7:0]        digit_c;
    state_t            after_digits_c;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            hex_q   <= 1'b0;
            ascii_q <= 8'h00;
            dp_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            ascii_q <= ascii_d;
            dp_q    <= dp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, datapath and output logic.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        ascii_d = ascii_q;
        dp_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        write_c = bus.en_16_x_baud && !bus.buffer_full;

        // Hex 10..15 maps to 'A'..'F': 0x41 - 10 = 0x37.
        nib_c = sr_q[SR_W-1 -: 4];
        if (hex_q) begin
            digit_c = (nib_c < 4'd10) ? (8'h30 + {4'h0, nib_c})
                                      : (8'h37 + {4'h0, nib_c});
        end else begin
            digit_c = sr_q[W-1] ? 8'h31 : 8'h30;
        end

        if (TERM == 2) begin
            after_digits_c = CR;
        end else if (TERM == 1) begin
            after_digits_c = LF;
        end else begin
            after_digits_c = IDLE;
        end

        case (state_q)
            IDLE: begin
                if (bus.send) begin
                    sr_d    = SR_W'(bus.binary_in);
                    hex_d   = bus.hex_mode;
                    cnt_d   = bus.hex_mode ? CNT_W'(D_HEX) : CNT_W'(W);
                    state_d = DIGITS;
                    busy_d  = 1'b1;
                end
            end
            DIGITS: begin
                if (write_c) begin
                    ascii_d = digit_c;
                    dp_d    = 1'b1;
                    sr_d    = hex_q ? (sr_q << 4) : (sr_q << 1);
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = after_digits_c;
                        if (after_digits_c == IDLE) begin
                            done_d = 1'b1;
                            busy_d = 1'b0;
                        end
                    end
                end
            end
            CR: begin
                if (write_c) begin
                    ascii_d = 8'h0D;
                    dp_d    = 1'b1;
                    state_d = LF;
                end
            end
            LF: begin
                if (write_c) begin
                    ascii_d = 8'h0A;
                    dp_d    = 1'b1;
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ascii_out    = ascii_q;
    assign bus.data_present = dp_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_send_word_as_ascii.sv
// Scoreboard bench for send_word_as_ascii. Four instances cover the
// terminator options and a non-multiple-of-4 width:
//   0: W=8  TERM=2   1: W=8  TERM=0   2: W=8  TERM=1   3: W=10 TERM=0
// Only one instance is active at a time, so a single ordered queue of
// {instance, last, char} entries serves as the scoreboard.
module tb_send_word_as_ascii;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        full;
    logic [3:0]  send_v;
    logic        hex_v;
    logic [31:0] word_v;

    logic [3:0]  dp_v, busy_v, done_v;
    logic [7:0]  ascii_v [4];

    logic [10:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_strobes = 0;
    logic        wr_ok_last = 1'b0;
    bit          en_rand = 1'b0;
    bit          rand_full = 1'b0;

    always #5 clk = ~clk;

    send_word_as_ascii_if #(.W(8))  if0 ();
    send_word_as_ascii_if #(.W(8))  if1 ();
    send_word_as_ascii_if #(.W(8))  if2 ();
    send_word_as_ascii_if #(.W(10)) if3 ();

    send_word_as_ascii #(.W(8),  .TERM(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    send_word_as_ascii #(.W(8),  .TERM(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    send_word_as_ascii #(.W(8),  .TERM(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    send_word_as_ascii #(.W(10), .TERM(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if0.en_16_x_baud = en;  assign if0.buffer_full = full;
    assign if1.en_16_x_baud = en;  assign if1.buffer_full = full;
    assign if2.en_16_x_baud = en;  assign if2.buffer_full = full;
    assign if3.en_16_x_baud = en;  assign if3.buffer_full = full;
    assign if0.send = send_v[0];   assign if0.hex_mode = hex_v;  assign if0.binary_in = word_v[7:0];
    assign if1.send = send_v[1];   assign if1.hex_mode = hex_v;  assign if1.binary_in = word_v[7:0];
    assign if2.send = send_v[2];   assign if2.hex_mode = hex_v;  assign if2.binary_in = word_v[7:0];
    assign if3.send = send_v[3];   assign if3.hex_mode = hex_v;  assign if3.binary_in = word_v[9:0];

    assign dp_v   = {if3.data_present, if2.data_present, if1.data_present, if0.data_present};
    assign busy_v = {if3.busy, if2.busy, if1.busy, if0.busy};
    assign done_v = {if3.done, if2.done, if1.done, if0.done};
    assign ascii_v[0] = if0.ascii_out;
    assign ascii_v[1] = if1.ascii_out;
    assign ascii_v[2] = if2.ascii_out;
    assign ascii_v[3] = if3.ascii_out;

    function automatic int w_of(input int id);
        return (id == 3) ? 10 : 8;
    endfunction

    function automatic int term_of(input int id);
        case (id)
            0:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference message: the word printed digit by digit from its numeric value,
    // then the terminator. Only the first 'limit' characters are expected.
    task automatic push_expected(input int id, input int val, input bit hx, input int limit);
        int         w, d, dig, v;
        logic [7:0] chars [$];
        w = w_of(id);
        v = val & ((1 << w) - 1);
        d = hx ? (w + 3) / 4 : w;
        for (int i = d - 1; i >= 0; i--) begin
            dig = hx ? ((v >> (4 * i)) & 15) : ((v >> i) & 1);
            chars.push_back(dig < 10 ? 8'(48 + dig) : 8'(65 + dig - 10));
        end
        if (term_of(id) == 2) chars.push_back(8'h0D);
        if (term_of(id) >= 1) chars.push_back(8'h0A);
        for (int i = 0; i < chars.size() && i < limit; i++)
            exp_q.push_back({2'(id), (i == chars.size() - 1), chars[i]});
    endtask

    // limit = 0 marks a request the DUT must ignore.
    task automatic send_req(input int id, input int val, input bit hx, input int limit);
        @(negedge clk);
        word_v     = 32'(val);
        hex_v      = hx;
        send_v[id] = 1'b1;
        if (limit > 0) push_expected(id, val, hx, limit);
        @(negedge clk);
        send_v = '0;
        word_v = $urandom;
        hex_v  = ~hx;
        if (limit > 0) check("busy_after_accept", int'(busy_v[id]), 1);
    endtask

    task automatic drain(input int id);
        int n = 0;
        while ((exp_q.size() != 0 || busy_v[id]) && n < 5000) begin
            @(negedge clk);
            n++;
            if (rand_full) full = ($urandom_range(0, 3) == 0);
        end
        full = 1'b0;
        check("drain_within_budget", (n < 5000) ? 1 : 0, 1);
        @(negedge clk);
        check("busy_low_after_message", int'(busy_v[id]), 0);
    endtask

    always @(posedge clk) wr_ok_last <= en && !full;

    // Monitor: every strobe must be paced, expected, and carry the right char/done/busy.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (dp_v[i]) begin
                logic [10:0] e;
                n_strobes++;
                check("write_pacing", int'(wr_ok_last), 1);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: inst %0d char 0x%0h, expected none", i, ascii_v[i]);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_instance", i, int'(e[10:9]));
                    check("strobe_char", int'(ascii_v[i]), int'(e[7:0]));
                    check("strobe_done", int'(done_v[i]), int'(e[8]));
                    check("busy_with_strobe", int'(busy_v[i]), int'(!e[8]));
                end
            end
        end
    end

    initial begin
        en = 1'b0;
        forever begin
            @(negedge clk);
            en = en_rand ? 1'($urandom_range(0, 1)) : ~en;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int s0;
        rst_n  = 1'b0;
        full   = 1'b0;
        send_v = '0;
        hex_v  = 1'b0;
        word_v = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            check("reset_outputs", int'({ascii_v[i], dp_v[i], busy_v[i], done_v[i]}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Binary 0xFF with CR/LF.
        send_req(0, 'hFF, 1'b0, 1000);
        drain(0);

        // Hex without terminator, and a zero-padded top digit at W=10.
        send_req(1, 'hA5, 1'b1, 1000);
        drain(1);
        send_req(3, 'h3FF, 1'b1, 1000);
        drain(3);

        // Stall for 20 clocks after the 3rd strobe of 0x81.
        send_req(0, 'h81, 1'b0, 1000);
        n = 0;
        while (exp_q.size() > 7 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("third_strobe_seen", (n < 200) ? 1 : 0, 1);
        #1 full = 1'b1;
        s0 = n_strobes;
        repeat (20) @(negedge clk);
        check("no_strobe_during_stall", n_strobes - s0, 0);
        full = 1'b0;
        drain(0);

        // A second send while busy is ignored.
        send_req(0, 'hFF, 1'b0, 1000);
        repeat (3) @(negedge clk);
        send_req(0, 'h00, 1'b0, 0);
        drain(0);

        // Reset one edge after the 4th strobe abandons the message.
        send_req(2, 'hFF, 1'b0, 4);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("fourth_strobe_seen", (n < 200) ? 1 : 0, 1);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("outputs_after_midmsg_reset",
              int'({ascii_v[2], dp_v[2], busy_v[2], done_v[2]}), 0);
        repeat (20) @(negedge clk);
        send_req(2, 'h0F, 1'b1, 1000);
        drain(2);

        // Randomized words, radices, pacing and back-pressure.
        en_rand   = 1'b1;
        rand_full = 1'b1;
        for (int k = 0; k < 30; k++) begin
            int id;
            id = $urandom_range(0, 3);
            send_req(id, int'($urandom), 1'($urandom_range(0, 1)), 1000);
            drain(id);
        end
        en_rand   = 1'b0;
        rand_full = 1'b0;
        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/send_word_as_ascii.md
# send_word_as_ascii

Parametrised successor to the binary-to-ASCII sender. It captures a W-bit word on a `send` strobe and emits it MSB-first as printable ASCII in binary or hexadecimal radix, with an optional CR/LF terminator. Characters go one per write strobe into the uart_tx6 transmit buffer. Writes are paced by `en_16_x_baud` and stall on `buffer_full`, so no character is lost when the UART FIFO backs up.

## Interface
Parameters:
- `W`, 8, width of the input word; W ≥ 1.
- `TERM`, 2, terminator: 0 = none, 1 = LF only, 2 = CR then LF.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en_16_x_baud`  in  1  pacing enable; a character write occurs only in a cycle where it is 1.
- `send`  in  1  start request; sampled only in IDLE.
- `hex_mode`  in  1  0 = binary digits, 1 = hex digits; sampled together with `send`.
- `binary_in`  in  W  word to print; sampled together with `send`.
- `buffer_full`  in  1  uart_tx6 `buffer_full`; 1 blocks writes.
- `ascii_out`  out  8  character, wired to uart_tx6 `data_in`.
- `data_present`  out  1  one-cycle write strobe, wired to uart_tx6 `buffer_write`.
- `busy`  out  1  high from acceptance until the final character is written.
- `done`  out  1  one-cycle pulse, coincident with the final `data_present`.

## Operation
- States: IDLE, DIGITS, CR, LF.
- IDLE, `send`=1 at an edge:
  - latch `binary_in` into the shift register and latch `hex_mode`.
  - load the digit counter with D: D = W in binary mode; D = ceil(W/4) in hex mode.
  - go to DIGITS; `busy`=1.
- Hex mode zero-extends the word to 4·D bits; the top digit carries the padding.
- Write condition (all states except IDLE): `en_16_x_baud`=1 and `buffer_full`=0 at an edge. When true, the edge registers `ascii_out`=char and `data_present`=1. In every other cycle `data_present`=0.
- DIGITS:
  - char is the most-significant remaining digit.
  - on a write, shift left by 1 bit (binary) or 4 bits (hex) and decrement the counter.
  - after the D-th write, go to CR if TERM=2, LF if TERM=1, IDLE if TERM=0.
- Digit encoding:
  - binary: 0x30 / 0x31.
  - hex: values 0–9 map to 0x30+n; values 10–15 map to 0x41+(n−10) (uppercase).
- CR: char 0x0D; on a write, go to LF.
- LF: char 0x0A; on a write, go to IDLE.
- Final write (the last char of the message): the same edge registers `done`=1, `busy`=0 and state=IDLE.
- `send` while busy is ignored; there is no queuing. `binary_in` and `hex_mode` changes after acceptance have no effect.
- `ascii_out` holds its last value between writes. Its value is defined only while `data_present`=1.
- Reset (`rst_n`=0 at an edge), including mid-message:
  - state=IDLE; shift register and counter cleared.
  - `ascii_out`=0x00, `data_present`=0, `busy`=0, `done`=0.
  - the partial message is abandoned; no further writes occur.
- Simultaneous `send` and `rst_n`=0: reset wins.
- Counter width: clog2(W+1) bits. Shift register width: max(W, 4·ceil(W/4)).

## Timing
- All outputs are registered.
- Acceptance: `send` sampled high at edge k → `busy`=1 after k.
- First write: earliest edge is k+1, so `data_present` is first high in the cycle after edge k+1.
- Message length: N = D + TERM characters.
- Throughput: one character per qualifying `en_16_x_baud` cycle. With `en_16_x_baud` toggling every clk, one character every 2 clocks.
- Stall: while `buffer_full`=1, no write occurs and state, counter and shift register hold. Resume happens on the first edge with the write condition true.
- `busy` falls with the final write. A new `send` is accepted at the next edge, i.e. during the `done` cycle.

## Test plan
- W=8, TERM=2, binary, `binary_in`=0xFF, `en_16_x_baud` toggling every clk:
  - expect 10 strobes: 0x31×8, 0x0D, 0x0A, spaced 2 clocks apart.
  - expect `done` with the 0x0A strobe; `busy` low after it.
- W=8, TERM=0, hex, 0xA5:
  - expect strobes 0x41, 0x35; `done` on the second.
  - W=10, hex, 0x3FF: expect 0x33, 0x46, 0x46 (zero-padded top digit).
- W=8, binary, 0x81, with `buffer_full` forced high for 20 clocks after the 3rd strobe:
  - expect no strobes during the stall.
  - after release, expect the remaining 0x30,0x30,0x30,0x30,0x31 in order; no duplicate or dropped character.
- Pulse `send` again with 0x00 while busy on 0xFF:
  - expect the second request ignored; the output remains "11111111\r\n" only.
- Assert `rst_n`=0 for one edge after the 4th strobe:
  - expect all outputs 0 the next cycle and no further strobes.
  - a new `send` (0x0F, hex, TERM=1) then yields 0x30, 0x46, 0x0A.
